pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
Multi-channel PWM generator with a shared, programmable-period timebase and per-channel double-buffered duty registers. It supports edge-aligned (sawtooth) and centre-aligned (triangle) modulation. Duty and period updates are accepted through a valid/ready load port and take effect only at a period boundary, so no glitches or runt pulses occur. It sits between the modulator DSP datapath and the output pins.

Parameters:
WIDTH, 8, bit width of counter, period and each duty word
CHANNELS, 4, number of PWM outputs sharing the timebase
CENTER_ALIGNED, 0, 0 = edge-aligned up-counter; 1 = centre-aligned up/down counter
DEFAULT_PERIOD, 2**WIDTH-1, active period after reset

Ports:
ipClk  input  1  clock, all logic on rising edge
ipReset  input  1  asynchronous, active-low reset
ipEnable  input  1  run timebase; low = hold/idle
ipPeriod  input  WIDTH  period word, captured with load
ipDutyCycle  input  CHANNELS*WIDTH  packed duty words; channel i at bits [i*WIDTH +: WIDTH]
ipDutyValid  input  1  load request
opDutyReady  output  1  load may be accepted
opPWM  output  CHANNELS  registered PWM outputs
opPeriodStart  output  1  one-cycle pulse, first cycle of each new period
opCount  output  WIDTH  current timebase count

Behaviour:
- Reset (ipReset low, asynchronous): Count=0, direction=up, active duties=0, active period=DEFAULT_PERIOD, pending flag=0, opPWM=0, opPeriodStart=0, opDutyReady=1.
- Load handshake: a transfer occurs on a clock edge with ipDutyValid && opDutyReady. It captures ipPeriod and all duty words into pending registers and sets pending. opDutyReady equals !pending. A pending load is never overwritten.
- Edge mode, enabled: if Count==ActivePeriod then Count<=0, else Count+1. Period is ActivePeriod+1 clocks.
- Centre mode, enabled: up && Count<P → Count+1; up && Count==P && P>0 → Count-1, direction down; down → Count-1, and direction returns to up when the next Count is 0. Sequence is 0,1..P,P-1..1. Period is 2P clocks.
- P==0 (either mode): Count stays 0 and every cycle is a boundary.
- Boundary: an enabled cycle whose next Count is 0.
  - On a boundary, pending is copied to active (period and duties), pending clears, and opPeriodStart<=1 for the next cycle.
  - A load accepted on the boundary cycle itself becomes pending and applies at the following boundary.
- Outputs: opPWM[i] <= ipEnable && (ActiveDuty[i] > Count), so the output lags opCount by one cycle.
  - Duty 0 → constant low.
  - Duty > P (edge mode) or duty > P (centre mode) → constant high.
  - Unsigned compare, no wrap.
- opCount: mirrors the Count register.
- Disabled (ipEnable low): Count<=0, direction<=up, opPWM<=0, opPeriodStart<=0. Any pending load transfers to active on the next edge. Loads are still accepted.
- Re-enable: counting starts from 0. No opPeriodStart pulse for the first period.
- Reset mid-operation: all state returns to reset values immediately. A pending load is discarded.

Decomposition:
- Package pwm_pkg: mode constants (PWM_EDGE=0, PWM_CENTER=1) and the duty-slice helper function.
- Sub-module pwm_timebase: counter, direction, boundary detection, opPeriodStart and opCount. It is parametrised by WIDTH and CENTER_ALIGNED.
- Top level: pending/active registers, handshake, and a generate loop of per-channel comparators.

Test Plan:
1. Reset: hold ipReset low, toggle clock → opPWM=0, opCount=0, opDutyReady=1, opPeriodStart=0. Release → Count increments from DEFAULT_PERIOD wrap.
2. Edge, WIDTH=8, CHANNELS=2, load P=9, duties {0,3} → ch0 high exactly 3 of every 10 clocks, ch1 always low, opPeriodStart every 10 clocks.
3. Saturation: P=9, duties {10,12} → both channels constant high, no low cycle across boundaries.
4. Shadow update: running P=9 duty 3, load duty 7 at opCount=4 → opDutyReady drops, current period stays 3 high, next period 7 high, ready returns after boundary. A second valid while not ready is ignored.
5. Centre, P=5, duty 2 → count sequence 0,1,2,3,4,5,4,3,2,1. ch high at counts 1,0,1 (3 of 10, symmetric about 0), opPeriodStart every 10 clocks.
6. Async reset mid-period: drive ipReset low at opCount=6 between edges → opPWM=0 and opCount=0 without a clock edge, pending cleared, opDutyReady=1.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// pwm_pkg : shared mode constants and duty-word slicing helper for pwm_multi
// Revision: 1.0
// ============================================================================
package pwm_pkg;

    localparam int PWM_EDGE   = 0;
    localparam int PWM_CENTER = 1;

    // LSB of a channel's duty word inside the packed duty bus
    function automatic int duty_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// pwm_timebase : shared edge/centre-aligned counter with period boundary pulse
// Revision: 1.0
// ============================================================================
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int CENTER_ALIGNED = PWM_EDGE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             boundary,
    output logic             period_start
);

    logic             dir_down;
    logic             dir_down_next;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next    = '0;
        dir_down_next = 1'b0;
        if (period == '0) begin
            count_next    = '0;
            dir_down_next = 1'b0;
        end else if (CENTER_ALIGNED == PWM_CENTER) begin
            if (!dir_down && (count < period)) begin
                count_next = count + 1'b1;
            end else begin
                count_next = count - 1'b1;
            end
            // Turn around at the peak; head back up once the valley is reached
            dir_down_next = (count_next != '0) && (dir_down || (count >= period));
        end else begin
            count_next = (count >= period) ? '0 : count + 1'b1;
        end
    end

    assign boundary = enable && (count_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            dir_down     <= 1'b0;
            period_start <= 1'b0;
        end else if (!enable) begin
            count        <= '0;
            dir_down     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            count        <= count_next;
            dir_down     <= dir_down_next;
            period_start <= boundary;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// pwm_multi : multi-channel PWM with shared timebase and shadowed duty/period
// Revision: 1.0
// ============================================================================
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int CHANNELS       = 4,
    parameter int CENTER_ALIGNED = PWM_EDGE,
    parameter int DEFAULT_PERIOD = 2**WIDTH - 1
) (
    input  logic                      ipClk,
    input  logic                      ipReset,
    input  logic                      ipEnable,
    input  logic [WIDTH-1:0]          ipPeriod,
    input  logic [CHANNELS*WIDTH-1:0] ipDutyCycle,
    input  logic                      ipDutyValid,
    output logic                      opDutyReady,
    output logic [CHANNELS-1:0]       opPWM,
    output logic                      opPeriodStart,
    output logic [WIDTH-1:0]          opCount
);

    logic                      pending;
    logic [WIDTH-1:0]          pending_period;
    logic [CHANNELS*WIDTH-1:0] pending_duty;
    logic [WIDTH-1:0]          active_period;
    logic [CHANNELS*WIDTH-1:0] active_duty;
    logic                      boundary;
    logic                      load_accept;
    logic                      apply;
    logic [CHANNELS-1:0]       pwm_next;

    pwm_timebase #(
        .WIDTH          (WIDTH),
        .CENTER_ALIGNED (CENTER_ALIGNED)
    ) u_timebase (
        .clk          (ipClk),
        .rst_n        (ipReset),
        .enable       (ipEnable),
        .period       (active_period),
        .count        (opCount),
        .boundary     (boundary),
        .period_start (opPeriodStart)
    );

    assign opDutyReady = !pending;
    assign load_accept = ipDutyValid && !pending;
    // Shadow copy happens only at a period boundary or while idle, never mid-period
    assign apply       = pending && (!ipEnable || boundary);

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            pending        <= 1'b0;
            pending_period <= '0;
            pending_duty   <= '0;
            active_period  <= WIDTH'(DEFAULT_PERIOD);
            active_duty    <= '0;
        end else begin
            if (load_accept) begin
                pending        <= 1'b1;
                pending_period <= ipPeriod;
                pending_duty   <= ipDutyCycle;
            end else if (apply) begin
                pending        <= 1'b0;
            end
            if (apply) begin
                active_period <= pending_period;
                active_duty   <= pending_duty;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign pwm_next[i] = ipEnable && (active_duty[duty_lsb(i, WIDTH) +: WIDTH] > opCount);
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            opPWM <= '0;
        end else begin
            opPWM <= pwm_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pwm_multi : directed self-checking bench for pwm_multi (edge + centre)
// Revision: 1.0
// ============================================================================
module tb_pwm_multi;

    localparam int W  = 8;
    localparam int CH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            e_en = 1'b0, e_valid = 1'b0;
    logic [W-1:0]    e_period = '0;
    logic [CH*W-1:0] e_duty = '0;
    logic            e_ready, e_ps;
    logic [CH-1:0]   e_pwm;
    logic [W-1:0]    e_count;

    logic            c_en = 1'b0, c_valid = 1'b0;
    logic [W-1:0]    c_period = '0;
    logic [CH*W-1:0] c_duty = '0;
    logic            c_ready, c_ps;
    logic [CH-1:0]   c_pwm;
    logic [W-1:0]    c_count;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH), .CENTER_ALIGNED(0)) u_edge (
        .ipClk(clk), .ipReset(rst_n), .ipEnable(e_en), .ipPeriod(e_period),
        .ipDutyCycle(e_duty), .ipDutyValid(e_valid), .opDutyReady(e_ready),
        .opPWM(e_pwm), .opPeriodStart(e_ps), .opCount(e_count)
    );

    pwm_multi #(.WIDTH(W), .CHANNELS(CH), .CENTER_ALIGNED(1)) u_ctr (
        .ipClk(clk), .ipReset(rst_n), .ipEnable(c_en), .ipPeriod(c_period),
        .ipDutyCycle(c_duty), .ipDutyValid(c_valid), .opDutyReady(c_ready),
        .opPWM(c_pwm), .opPeriodStart(c_ps), .opCount(c_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle-load: accepted on first edge, copied to active on the next
    task automatic edge_load(input logic [W-1:0] p, input logic [CH*W-1:0] d);
        e_en = 1'b0; e_valid = 1'b1; e_period = p; e_duty = d;
        tick();
        check("edge_load_busy", 32'(e_ready), 32'd0);
        e_valid = 1'b0;
        tick();
        check("edge_load_done", 32'(e_ready), 32'd1);
    endtask

    task automatic ctr_load(input logic [W-1:0] p, input logic [CH*W-1:0] d);
        c_en = 1'b0; c_valid = 1'b1; c_period = p; c_duty = d;
        tick();
        c_valid = 1'b0;
        tick();
        check("ctr_load_done", 32'(c_ready), 32'd1);
    endtask

    function automatic int tri_cnt(input int m);
        return (m <= 5) ? m : 10 - m;
    endfunction

    initial begin
        int hi0, hi1, lo, cerr, perr, serr;

        // Reset state
        repeat (3) tick();
        check("rst_pwm",   32'(e_pwm),   32'd0);
        check("rst_count", 32'(e_count), 32'd0);
        check("rst_ready", 32'(e_ready), 32'd1);
        check("rst_ps",    32'(e_ps),    32'd0);
        check("rst_ccount", 32'(c_count), 32'd0);

        // Default period 255 wraps after 256 clocks
        rst_n = 1'b1; e_en = 1'b1;
        repeat (255) tick();
        check("dflt_peak", 32'(e_count), 32'd255);
        tick();
        check("dflt_wrap", 32'(e_count), 32'd0);
        check("dflt_ps",   32'(e_ps),    32'd1);
        check("dflt_pwm",  32'(e_pwm),   32'd0);

        // Edge mode P=9, ch0=3, ch1=0
        edge_load(8'd9, {8'd0, 8'd3});
        e_en = 1'b1;
        hi0 = 0; hi1 = 0; cerr = 0; serr = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            hi0 += int'(e_pwm[0]);
            hi1 += int'(e_pwm[1]);
            if (e_count !== W'(k % 10)) cerr++;
            if (e_ps !== ((k % 10) == 0)) serr++;
        end
        check("edge_ch0_high", 32'(hi0), 32'd6);
        check("edge_ch1_high", 32'(hi1), 32'd0);
        check("edge_count_seq", 32'(cerr), 32'd0);
        check("edge_ps_seq", 32'(serr), 32'd0);

        // Saturation: duties above P stay high across boundaries
        edge_load(8'd9, {8'd12, 8'd10});
        e_en = 1'b1;
        lo = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (e_pwm !== 2'b11) lo++;
        end
        check("sat_low_cycles", 32'(lo), 32'd0);

        // Shadow update mid-period, second request while busy ignored
        edge_load(8'd9, {8'd0, 8'd3});
        e_en = 1'b1;
        hi0 = 0; hi1 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 10) hi0 += int'(e_pwm[0]);
            else         hi1 += int'(e_pwm[0]);
            if (k == 4) begin
                e_valid = 1'b1; e_duty = {8'd0, 8'd7};
            end
            if (k == 5) begin
                check("shadow_busy", 32'(e_ready), 32'd0);
                e_duty = {8'd0, 8'd1};
            end
            if (k == 8) e_valid = 1'b0;
            if (k == 9) check("shadow_still_busy", 32'(e_ready), 32'd0);
            if (k == 10) begin
                check("shadow_ready_back", 32'(e_ready), 32'd1);
                check("shadow_ps", 32'(e_ps), 32'd1);
            end
        end
        check("shadow_old_high", 32'(hi0), 32'd3);
        check("shadow_new_high", 32'(hi1), 32'd7);
        check("shadow_idle_ready", 32'(e_ready), 32'd1);

        // Async reset mid-period with a load pending
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) begin
                e_valid = 1'b1; e_duty = {8'd0, 8'd2};
            end
            if (k == 6) e_valid = 1'b0;
        end
        check("pre_rst_count", 32'(e_count), 32'd6);
        check("pre_rst_ready", 32'(e_ready), 32'd0);
        check("pre_rst_pwm",   32'(e_pwm),   32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pwm",   32'(e_pwm),   32'd0);
        check("arst_count", 32'(e_count), 32'd0);
        check("arst_ready", 32'(e_ready), 32'd1);
        check("arst_ps",    32'(e_ps),    32'd0);
        e_en = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (2) tick();
        e_en = 1'b1;
        hi0 = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            hi0 += int'(e_pwm[0]);
        end
        check("arst_discard_pwm",   32'(hi0),     32'd0);
        check("arst_discard_count", 32'(e_count), 32'd10);

        // Centre mode P=5, ch0=2
        ctr_load(8'd5, {8'd0, 8'd2});
        c_en = 1'b1;
        hi0 = 0; hi1 = 0; cerr = 0; perr = 0; serr = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            hi0 += int'(c_pwm[0]);
            hi1 += int'(c_pwm[1]);
            if (c_count !== W'(tri_cnt(k % 10))) cerr++;
            if (c_pwm[0] !== (tri_cnt((k - 1) % 10) < 2)) perr++;
            if (c_ps !== ((k % 10) == 0)) serr++;
            if (k == 5) check("ctr_peak", 32'(c_count), 32'd5);
            if (k == 6) check("ctr_descend", 32'(c_count), 32'd4);
        end
        check("ctr_count_seq", 32'(cerr), 32'd0);
        check("ctr_pwm_seq",   32'(perr), 32'd0);
        check("ctr_ps_seq",    32'(serr), 32'd0);
        check("ctr_ch0_high",  32'(hi0),  32'd6);
        check("ctr_ch1_high",  32'(hi1),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
